mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Shares one 8-bit 2:1 select datapath between two independent valid/ready requesters, A and B.
- Picks a requester each cycle using round-robin priority and drives the mux select.
- Registers the selected byte, together with a source tag, into a single-entry output stage with a valid/ready handshake.
- Sits between two producer blocks and one downstream consumer. Also provides saturating per-source grant counters for debug and status.

Parameters:
- DATA_W, 8, width of each data path and of the output data.
- CNT_W, 8, width of each saturating grant counter.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- a_valid_i  input  1  requester A has a beat.
- a_data_i  input  DATA_W  requester A data.
- a_ready_o  output  1  A beat accepted this cycle.
- b_valid_i  input  1  requester B has a beat.
- b_data_i  input  DATA_W  requester B data.
- b_ready_o  output  1  B beat accepted this cycle.
- out_valid_o  output  1  output register holds a beat.
- out_data_o  output  DATA_W  registered selected data.
- out_src_o  output  1  source of the held beat; 1 = A, 0 = B.
- out_ready_i  input  1  consumer accepts the beat.
- sel_o  output  1  combinational mux select for this cycle; 1 = A.
- clr_cnt_i  input  1  synchronous clear of both grant counters.
- cnt_a_o  output  CNT_W  number of A grants, saturating.
- cnt_b_o  output  CNT_W  number of B grants, saturating.

Behaviour:
- Reset (async assert, sync release):
  - out_valid_o=0, out_data_o=0, out_src_o=0.
  - Internal last_grant=B, so A wins the first contention.
  - cnt_a_o=0, cnt_b_o=0.
  - a_ready_o=b_ready_o=0 while in reset.
- Reset mid-operation discards the held beat; no accepted beat is replayed.
- load = !out_valid_o || out_ready_i, i.e. the output register is free or is being drained this cycle.
- Grant (combinational):
  - Only A valid -> A.
  - Only B valid -> B.
  - Both valid -> the source that is not last_grant.
  - Neither valid -> no grant. sel_o keeps its last granted value so the mux input does not toggle.
- a_ready_o = load && grant==A; b_ready_o = load && grant==B. At most one of the two is high in any cycle.
- Ready depends combinationally on out_ready_i (one ready path). Valid never depends on ready.
- On a clock edge with load and a grant:
  - out_data_o <= granted data; out_src_o <= grant; out_valid_o <= 1.
  - last_grant <= grant; the granted counter increments, saturating at 2^CNT_W-1.
- On a clock edge with load and no grant: out_valid_o <= 0. out_data_o and out_src_o hold their values.
- When !load, everything holds: out_data_o, out_src_o, out_valid_o and last_grant are stable while out_valid_o=1 and out_ready_i=0.
- Throughput: one beat per cycle when out_ready_i is held at 1. Latency is 1 cycle from the input handshake to out_valid_o.
- Fairness: with both sources requesting continuously, grants alternate A,B,A,B. Neither source waits more than one grant.
- Requester rule: valid and data must stay stable until ready. The arbiter does not check this.
- A valid that drops before being granted is not counted and is not remembered.
- clr_cnt_i zeroes both counters. A clear in the same cycle as a grant wins: the counter becomes 0, not 1.
- Saturated counter plus a further grant: the counter stays at max.
- State encoding: EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on a grant while out_ready_i=1, or while out_ready_i=0 (hold).
  - FULL -> EMPTY when out_ready_i=1 and there is no grant.

Decomposition:
- Shared package holds:
  - typedef src_t (1 bit), with constants SRC_A=1 and SRC_B=0.
  - default DATA_W and CNT_W.
- One natural sub-module: rr2_grant. It is purely combinational and maps (a_valid, b_valid, last_grant) to (grant_vld, grant).
- The top level holds the mux select, the output register, last_grant and the counters.

Test Plan:
- Reset check: assert rst_n_i low for 3 cycles with both valids high -> all outputs 0, no ready pulses. After release, first grant goes to A; cnt_a_o=1.
- Alternation: A=0x11 and B=0x22 both held valid, out_ready_i=1 for 6 cycles -> out_data_o sequence 11,22,11,22,11,22; out_src_o 1,0,1,0,1,0; cnt_a_o=cnt_b_o=3.
- Single source: only B valid, data 0x05 to 0x08 over 4 cycles -> every cycle granted to B, out_data_o 05..08; cnt_a_o stays 0.
- Backpressure: beat 0xAA latched, then out_ready_i=0 for 4 cycles with both sources valid -> out_data_o stays 0xAA; a_ready_o=b_ready_o=0; out_valid_o=1. On release, the next grant goes to the source not granted last.
- Counters: drive CNT_W=2 (counter max 3) with A-only for 5 grants -> cnt_a_o saturates at 3. clr_cnt_i in the same cycle as a grant -> cnt_a_o=0.
- Async reset mid-stream: pull rst_n_i low between edges while out_valid_o=1 -> out_valid_o drops immediately, without waiting for a clock edge. After release, the first contention grants A.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  // Source tag: 1 = requester A, 0 = requester B
  typedef logic src_t;
  localparam src_t SRC_A = 1'b1;
  localparam src_t SRC_B = 1'b0;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Output stage occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2_rr_arbiter_rr2_grant.sv
// Two-way round-robin grant: on contention the source that did not win last time wins.
module rr2_grant
  import mux2_rr_arbiter_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  src_t last_grant,
  output logic grant_vld,
  output src_t grant
);

  always_comb begin
    grant_vld = a_valid || b_valid;
    grant     = SRC_B;
    if (a_valid && b_valid) begin
      grant = (last_grant == SRC_A) ? SRC_B : SRC_A;
    end else if (a_valid) begin
      grant = SRC_A;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 byte mux between two valid/ready requesters,
// feeding a single-entry registered output stage, with saturating per-source grant counters.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  input  logic              out_ready_i,
  output logic              sel_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  cnt_a_o,
  output logic [CNT_W-1:0]  cnt_b_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_reg, state_next;
  src_t              last_grant_reg;
  logic [DATA_W-1:0] out_data_reg;
  src_t              out_src_reg;
  logic [CNT_W-1:0]  cnt_reg [2];

  logic grant_raw_vld;
  src_t grant;
  logic grant_vld;
  logic load;
  logic take;

  rr2_grant u_grant (
    .a_valid    (a_valid_i),
    .b_valid    (b_valid_i),
    .last_grant (last_grant_reg),
    .grant_vld  (grant_raw_vld),
    .grant      (grant)
  );

  // No grant is visible while reset is held, so ready and select stay quiet.
  assign grant_vld = grant_raw_vld && rst_n_i;
  assign load      = (state_reg == ST_EMPTY) || out_ready_i;
  assign take      = load && grant_vld;

  assign a_ready_o = take && (grant == SRC_A);
  assign b_ready_o = take && (grant == SRC_B);
  // Idle cycles keep the previous select so the mux input does not toggle.
  assign sel_o     = grant_vld ? grant : last_grant_reg;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = grant_vld ? ST_FULL : ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_data_reg   <= '0;
      out_src_reg    <= SRC_B;
      last_grant_reg <= SRC_B;
    end else if (take) begin
      out_data_reg   <= sel_o ? a_data_i : b_data_i;
      out_src_reg    <= grant;
      last_grant_reg <= grant;
    end
  end

  // Index 1 counts A grants, index 0 counts B grants (matches the source tag).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt_reg[gi] <= '0;
        end else if (clr_cnt_i) begin
          cnt_reg[gi] <= '0;
        end else if (take && (grant == src_t'(gi)) && (cnt_reg[gi] != CNT_MAX)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign out_valid_o = (state_reg == ST_FULL);
  assign out_data_o  = out_data_reg;
  assign out_src_o   = out_src_reg;
  assign cnt_a_o     = cnt_reg[1];
  assign cnt_b_o     = cnt_reg[0];

endmodule
